rucksack_priority_engine: RTL and testbench



---
 rtl/rucksack_priority_engine.sv | 190 +++++++++++++++++++
 tb/tb_rucksack_priority_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rucksack_priority_engine.sv
// Purpose: scores item streams by the highest item type common to both halves
//          of a line (mode 0) or to all lines of a group (mode 1), summing results.
// Latency: mode 0 line costs len SPLIT cycles + 1 SCORE cycle after its EOL;
//          mode 1 group costs 1 SCORE cycle after the group's last EOL.
// Backpressure: in_ready is high only in FILL; items wait while SPLIT/SCORE run.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, mode              begin a run (honoured in IDLE/DONE), mode latched on start
//   in_data/in_valid/in_ready item stream, code 0 = end of line
//   sum, lines               running score and count of non-empty lines
//   done, busy               run finished / run in progress
//   err_*                    sticky error flags, cleared on start or reset
module rucksack_priority_engine #(
    parameter int NUM_TYPES = 64,
    parameter int ITEM_W    = 8,
    parameter int MAX_LEN   = 256,
    parameter int GROUP_N   = 3,
    parameter int SUM_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ITEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  sum,
    output logic              done,
    output logic              busy,
    output logic [15:0]       lines,
    output logic              err_odd,
    output logic              err_overflow,
    output logic              err_range,
    output logic              err_nocommon,
    output logic              err_partial
);
    localparam int IW = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = (GROUP_N > 1) ? $clog2(GROUP_N) : 1;

    typedef enum logic [2:0] {IDLE, FILL, SPLIT, SCORE, DONE} state_t;

    state_t               state, state_nx;
    logic                 mode_r;
    logic [LW-1:0]        len, idx, half;
    logic [NUM_TYPES-1:0] mask_a, mask_b, line_mask, group_mask, common;
    logic [GW-1:0]        grp_cnt;
    logic [IW-1:0]        line_buf [MAX_LEN];
    logic [IW-1:0]        code, rd_code, hi;
    logic                 xfer, is_eol, in_range, len_full, grp_last;

    assign in_ready = (state == FILL);
    assign busy     = (state == FILL) || (state == SPLIT) || (state == SCORE);
    assign done     = (state == DONE);
    assign xfer     = in_valid && in_ready;
    assign is_eol   = (in_data == '0);
    assign in_range = (int'(in_data) < NUM_TYPES);
    assign code     = in_data[IW-1:0];
    assign len_full = (len == LW'(MAX_LEN));
    assign grp_last = (grp_cnt == GW'(GROUP_N - 1));
    assign half     = len >> 1;
    assign rd_code  = line_buf[idx[AW-1:0]];

    // Highest common type; the loop lets later (higher) bits overwrite lower ones.
    always_comb begin
        common = mode_r ? group_mask : (mask_a & mask_b);
        hi     = '0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (common[i]) hi = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = FILL;
            FILL: begin
                if (xfer && is_eol) begin
                    if (len == '0)    state_nx = DONE;
                    else if (!mode_r) state_nx = SPLIT;
                    else if (grp_last) state_nx = SCORE;
                end
            end
            SPLIT:   if (idx == len - LW'(1)) state_nx = SCORE;
            SCORE:   state_nx = FILL;
            default: state_nx = IDLE;
        endcase
    end

    // Line buffer holds only mode-0 items; it needs no reset.
    always_ff @(posedge clk) begin
        if (state == FILL && xfer && !is_eol && in_range && !mode_r && !len_full)
            line_buf[len[AW-1:0]] <= code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r       <= 1'b0;
            len          <= '0;
            idx          <= '0;
            mask_a       <= '0;
            mask_b       <= '0;
            line_mask    <= '0;
            group_mask   <= '0;
            grp_cnt      <= '0;
            sum          <= '0;
            lines        <= '0;
            err_odd      <= 1'b0;
            err_overflow <= 1'b0;
            err_range    <= 1'b0;
            err_nocommon <= 1'b0;
            err_partial  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_r       <= mode;
                        len          <= '0;
                        idx          <= '0;
                        mask_a       <= '0;
                        mask_b       <= '0;
                        line_mask    <= '0;
                        group_mask   <= '0;
                        grp_cnt      <= '0;
                        sum          <= '0;
                        lines        <= '0;
                        err_odd      <= 1'b0;
                        err_overflow <= 1'b0;
                        err_range    <= 1'b0;
                        err_nocommon <= 1'b0;
                        err_partial  <= 1'b0;
                    end
                end
                FILL: begin
                    if (xfer) begin
                        if (is_eol) begin
                            if (len != '0) begin
                                if (lines != 16'hFFFF) lines <= lines + 16'd1;
                                idx <= '0;
                                if (!mode_r) begin
                                    if (len[0]) err_odd <= 1'b1;
                                end else begin
                                    group_mask <= (grp_cnt == '0) ? line_mask
                                                                  : (group_mask & line_mask);
                                    line_mask  <= '0;
                                    len        <= '0;
                                    grp_cnt    <= grp_last ? '0 : grp_cnt + GW'(1);
                                end
                            end else if (mode_r && grp_cnt != '0) begin
                                // Run ended inside an incomplete group: it scores nothing.
                                err_partial <= 1'b1;
                            end
                        end else if (!in_range) begin
                            err_range <= 1'b1;
                        end else if (!mode_r) begin
                            if (len_full) err_overflow <= 1'b1;
                            else          len <= len + LW'(1);
                        end else begin
                            // Mode 1 keeps len only to tell empty lines apart.
                            line_mask[code] <= 1'b1;
                            if (!len_full) len <= len + LW'(1);
                        end
                    end
                end
                SPLIT: begin
                    if (idx < half) mask_a[rd_code] <= 1'b1;
                    else            mask_b[rd_code] <= 1'b1;
                    idx <= idx + LW'(1);
                end
                SCORE: begin
                    sum <= sum + SUM_W'(hi);
                    if (common == '0) err_nocommon <= 1'b1;
                    mask_a     <= '0;
                    mask_b     <= '0;
                    group_mask <= '0;
                    len        <= '0;
                    idx        <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rucksack_priority_engine.sv
module tb_rucksack_priority_engine;
    logic        clk = 1'b0;
    logic        rst, start, mode, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, done, busy;
    logic [31:0] sum;
    logic [15:0] lines;
    logic        e_odd, e_ovf, e_rng, e_noc, e_par;
    logic        s_in_ready, s_done, s_busy;
    logic [31:0] s_sum;
    logic [15:0] s_lines;
    logic        s_odd, s_ovf, s_rng, s_noc, s_par;
    logic [4:0]  errs, s_errs;

    assign errs   = {e_odd, e_ovf, e_rng, e_noc, e_par};
    assign s_errs = {s_odd, s_ovf, s_rng, s_noc, s_par};

    always #5 clk = ~clk;

    rucksack_priority_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .done(done), .busy(busy), .lines(lines),
        .err_odd(e_odd), .err_overflow(e_ovf), .err_range(e_rng),
        .err_nocommon(e_noc), .err_partial(e_par)
    );

    // Short-buffer instance shares the input stream; only checked for overflow.
    rucksack_priority_engine #(.MAX_LEN(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .sum(s_sum), .done(s_done), .busy(s_busy), .lines(s_lines),
        .err_odd(s_odd), .err_overflow(s_ovf), .err_range(s_rng),
        .err_nocommon(s_noc), .err_partial(s_par)
    );

    typedef struct packed {
        logic        mode;
        int          off;
        int          n;
        logic [31:0] sum;
        logic [15:0] lines;
        logic [4:0]  errs;   // {odd, overflow, range, nocommon, partial}
    } vec_t;

    vec_t       vecs [12];
    int         nv = 0;
    logic [7:0] stream [2048];
    int         sp = 0;
    int         tests = 0;
    int         fails = 0;

    string aoc [6] = '{
        "vJrwpWtwJgWrhcsFMMfFFhFp",
        "jqHRNqRjqzjGDLGLrsFMfFZSrLrFZsSL",
        "PmmdzqPrVvPwwTWBwg",
        "wMqvLMZHhHMvwLHjbvcjnnSBnvTQFn",
        "ttgJtRGJQctTZtZT",
        "CrZsJsPPZsGzwwsLwLmpwMDw"
    };

    function automatic logic [7:0] prio(input logic [7:0] c);
        if (c >= 8'd97) return c - 8'd96;   // a..z -> 1..26
        else            return c - 8'd38;   // A..Z -> 27..52
    endfunction

    task automatic push(input logic [7:0] c);
        stream[sp] = c;
        sp++;
    endtask

    task automatic push_aoc();
        for (int l = 0; l < 6; l++) begin
            for (int k = 0; k < aoc[l].len(); k++) push(prio(aoc[l][k]));
            push(8'd0);
        end
        push(8'd0);
    endtask

    task automatic vec_open(input logic m, input logic [31:0] s,
                            input logic [15:0] l, input logic [4:0] e);
        vecs[nv].mode  = m;
        vecs[nv].off   = sp;
        vecs[nv].sum   = s;
        vecs[nv].lines = l;
        vecs[nv].errs  = e;
    endtask

    task automatic vec_close();
        vecs[nv].n = sp - vecs[nv].off;
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic m);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; presents one item once the main instance is ready.
    task automatic send(input logic [7:0] d);
        int w = 0;
        while (!in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
        end
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int w = 0;
        while (!done && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int gap;
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;

        // Directed vectors: mode, expected sum, lines, error flags
        vec_open(1'b0, 32'd7, 16'd1, 5'b00000);
        push(5); push(7); push(9); push(7); push(0); push(0); vec_close();
        vec_open(1'b0, 32'd157, 16'd6, 5'b00000); push_aoc(); vec_close();
        vec_open(1'b1, 32'd70, 16'd6, 5'b00000);  push_aoc(); vec_close();
        vec_open(1'b0, 32'd0, 16'd1, 5'b10010);
        push(1); push(2); push(3); push(0); push(0); vec_close();
        vec_open(1'b0, 32'd0, 16'd1, 5'b00010);
        push(1); push(2); push(3); push(4); push(0); push(0); vec_close();
        vec_open(1'b0, 32'd20, 16'd1, 5'b00100);
        push(10); push(70); push(20); push(10); push(20); push(0); push(0); vec_close();
        vec_open(1'b1, 32'd0, 16'd2, 5'b00001);
        push(4); push(5); push(0); push(5); push(6); push(0); push(0); vec_close();
        vec_open(1'b1, 32'd3, 16'd3, 5'b00000);
        push(1); push(2); push(3); push(0); push(3); push(9); push(0);
        push(3); push(1); push(9); push(0); push(0); vec_close();
        vec_open(1'b0, 32'd71, 16'd2, 5'b00000);
        push(63); push(1); push(63); push(2); push(0);
        push(3); push(8); push(8); push(3); push(0); push(0); vec_close();
        vec_open(1'b0, 32'd0, 16'd0, 5'b00000); push(0); vec_close();

        repeat (3) @(negedge clk);
        check("rst_sum",   sum, 32'd0);
        check("rst_lines", {16'd0, lines}, 32'd0);
        check("rst_flags", {27'd0, done, busy, in_ready, 2'b00}, 32'd0);
        check("rst_errs",  {27'd0, errs}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < nv; v++) begin
            do_start(vecs[v].mode);
            for (int k = 0; k < vecs[v].n; k++) send(stream[vecs[v].off + k]);
            wait_done($sformatf("v%0d", v));
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_done_hold", v), {31'd0, done}, 32'd1);
            check($sformatf("v%0d_sum", v), sum, vecs[v].sum);
            check($sformatf("v%0d_lines", v), {16'd0, lines}, {16'd0, vecs[v].lines});
            check($sformatf("v%0d_errs", v), {27'd0, errs}, {27'd0, vecs[v].errs});
        end

        // Overflow on the 4-deep instance; the full instance sees an odd line.
        do_start(1'b0);
        send(2); send(3); send(3); send(2); send(9); send(0); send(0);
        wait_done("ovf");
        check("ovf_small_done", {31'd0, s_done}, 32'd1);
        check("ovf_small_sum", s_sum, 32'd3);
        check("ovf_small_lines", {16'd0, s_lines}, 32'd1);
        check("ovf_small_errs", {27'd0, s_errs}, 32'b01000);
        check("ovf_big_sum", sum, 32'd3);
        check("ovf_big_errs", {27'd0, errs}, 32'b10000);

        // Reset in the middle of SPLIT after one line has already scored.
        do_start(1'b0);
        check("start_clears_done", {30'd0, done, busy}, 32'b01);
        send(5); send(7); send(9); send(7); send(0);
        for (int k = 0; k < aoc[1].len(); k++) send(prio(aoc[1][k]));
        send(0);
        repeat (3) @(negedge clk);
        check("split_busy", {30'd0, busy, in_ready}, 32'b10);
        check("split_sum", sum, 32'd7);
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {27'd0, done, busy, in_ready, s_busy, s_in_ready}, 32'd0);
        check("mid_rst_sum", sum, 32'd0);
        check("mid_rst_lines", {16'd0, lines}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {29'd0, done, busy, in_ready}, 32'd0);

        // Rerun with stalls and a start pulse mid-run that must be ignored.
        do_start(1'b0);
        send(5);
        repeat (3) @(negedge clk);
        do_start(1'b1);
        send(7);
        repeat (2) @(negedge clk);
        send(9); send(7); send(0);
        gap = 0;
        while (!in_ready && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("split_score_gap", gap, 32'd5);
        send(0);
        wait_done("stall");
        check("stall_sum", sum, 32'd7);
        check("stall_lines", {16'd0, lines}, 32'd1);
        check("stall_errs", {27'd0, errs}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
